// File: rtl/vec_be_checker.sv
// Receiving-end byte-enable checker for one vector transfer.
// A transfer of avl elements at width 1<<sew bytes arrives as DATA_WIDTH beats;
// each beat's byte enable must equal the packed low-aligned mask implied by
// the elements still outstanding. Any mismatch parks the block in a sticky
// error state until the next start.
module vec_be_checker #(
    parameter int VLEN          = 16384,
    parameter int AVL_WIDTH     = $clog2(VLEN/8) + 1,
    parameter int DATA_WIDTH    = 64,
    parameter int DW_B          = DATA_WIDTH/8,
    parameter int SEW_WIDTH     = 2,
    parameter bit ENABLE_64_BIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SEW_WIDTH-1:0] start_sew,
    input  logic [AVL_WIDTH-1:0] start_avl,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW_B-1:0]      in_be,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [AVL_WIDTH-1:0] err_beat,
    output logic [DW_B-1:0]      err_be,
    output logic [AVL_WIDTH-1:0] elem_count,
    output logic [AVL_WIDTH-1:0] beat_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ERR    = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [SEW_WIDTH-1:0] sew_q, sew_d;
    logic [AVL_WIDTH-1:0] avl_q, avl_d;
    logic [AVL_WIDTH-1:0] elem_q, elem_d;
    logic [AVL_WIDTH-1:0] beat_q, beat_d;
    logic                 done_q, done_d;
    logic [AVL_WIDTH-1:0] err_beat_q, err_beat_d;
    logic [DW_B-1:0]      err_be_q, err_be_d;

    // Expected mask for the current beat: n = min(avl - elem_count, elements
    // per beat), and the low n*W_B byte lanes are enabled.
    logic [AVL_WIDTH-1:0] epb;
    logic [AVL_WIDTH-1:0] rem;
    logic [AVL_WIDTH-1:0] n_elem;
    logic [AVL_WIDTH-1:0] n_bytes;
    logic [AVL_WIDTH-1:0] elem_sum;
    logic [DW_B-1:0]      exp_be;

    assign epb      = AVL_WIDTH'(DW_B) >> sew_q;
    assign rem      = avl_q - elem_q;
    assign n_elem   = (rem < epb) ? rem : epb;
    assign n_bytes  = n_elem << sew_q;
    assign elem_sum = elem_q + n_elem;

    genvar gi;
    generate
        for (gi = 0; gi < DW_B; gi++) begin : g_mask
            assign exp_be[gi] = (AVL_WIDTH'(gi) < n_bytes);
        end
    endgenerate

    // Next-state logic: start handling in IDLE/ERR, beat checking in ACTIVE.
    always_comb begin
        state_d    = state_q;
        sew_d      = sew_q;
        avl_d      = avl_q;
        elem_d     = elem_q;
        beat_d     = beat_q;
        done_d     = 1'b0;
        err_beat_d = err_beat_q;
        err_be_d   = err_be_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    sew_d      = start_sew;
                    avl_d      = start_avl;
                    elem_d     = '0;
                    beat_d     = '0;
                    err_beat_d = '0;
                    err_be_d   = '0;
                    if ((start_sew == SEW_WIDTH'(3)) && !ENABLE_64_BIT) begin
                        state_d = S_ERR;
                    end else if (start_avl == '0) begin
                        // Empty transfer completes without accepting a beat.
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                if (in_valid) begin
                    if (in_be == exp_be) begin
                        elem_d = elem_sum;
                        beat_d = beat_q + 1'b1;
                        if (elem_sum == avl_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        // Bad beat is consumed but does not advance counters.
                        state_d    = S_ERR;
                        err_beat_d = beat_q;
                        err_be_d   = in_be;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sew_q      <= '0;
            avl_q      <= '0;
            elem_q     <= '0;
            beat_q     <= '0;
            done_q     <= 1'b0;
            err_beat_q <= '0;
            err_be_q   <= '0;
        end else begin
            state_q    <= state_d;
            sew_q      <= sew_d;
            avl_q      <= avl_d;
            elem_q     <= elem_d;
            beat_q     <= beat_d;
            done_q     <= done_d;
            err_beat_q <= err_beat_d;
            err_be_q   <= err_be_d;
        end
    end

    assign busy       = (state_q == S_ACTIVE);
    assign in_ready   = busy;
    assign err        = (state_q == S_ERR);
    assign done       = done_q;
    assign err_beat   = err_beat_q;
    assign err_be     = err_be_q;
    assign elem_count = elem_q;
    assign beat_count = beat_q;

endmodule

// File: tb/tb_vec_be_checker.sv
// Directed bench for vec_be_checker; a second instance is built with
// 64-bit elements disabled to exercise the illegal-sew path.
module tb_vec_be_checker;

    localparam int AW = 12;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, start0;
    logic [1:0]    start_sew;
    logic [AW-1:0] start_avl;
    logic          in_valid;
    logic [BW-1:0] in_be;

    logic          in_ready, busy, done, err;
    logic [AW-1:0] err_beat, elem_count, beat_count;
    logic [BW-1:0] err_be;

    logic          in_ready0, busy0, done0, err0;
    logic [AW-1:0] err_beat0, elem_count0, beat_count0;
    logic [BW-1:0] err_be0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vec_be_checker #(.ENABLE_64_BIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_sew(start_sew),
        .start_avl(start_avl), .in_valid(in_valid), .in_ready(in_ready),
        .in_be(in_be), .busy(busy), .done(done), .err(err),
        .err_beat(err_beat), .err_be(err_be), .elem_count(elem_count),
        .beat_count(beat_count)
    );

    vec_be_checker #(.ENABLE_64_BIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .start_sew(start_sew),
        .start_avl(start_avl), .in_valid(in_valid), .in_ready(in_ready0),
        .in_be(in_be), .busy(busy0), .done(done0), .err(err0),
        .err_beat(err_beat0), .err_be(err_be0), .elem_count(elem_count0),
        .beat_count(beat_count0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] sew, input logic [AW-1:0] avl);
        start = 1'b1; start_sew = sew; start_avl = avl;
        tick();
        start = 1'b0;
        $display("start sew=%0d avl=%0d", sew, avl);
    endtask

    task automatic beat(input logic [BW-1:0] be);
        in_valid = 1'b1; in_be = be;
        tick();
        in_valid = 1'b0;
        $display("beat be=%02h done=%0b err=%0b elem=%0d beats=%0d", be, done, err, elem_count, beat_count);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b%b%b want=0000", busy, in_ready, done, err); end
        total++; if (elem_count !== '0 || beat_count !== '0 || err_beat !== '0 || err_be !== '0) begin bad++; $display("FAIL reset_counts got=%0d/%0d/%0d/%0h want=0", elem_count, beat_count, err_beat, err_be); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sew0_gaps();
        do_start(2'd0, 12'd20);
        total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL s0_active got=%b%b want=11", in_ready, busy); end
        tick();
        beat(8'hFF);
        tick(); tick();
        beat(8'hFF);
        total++; if (elem_count !== 12'd16 || done !== 1'b0) begin bad++; $display("FAIL s0_mid got=%0d/%b want=16/0", elem_count, done); end
        tick();
        beat(8'h0F);
        total++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL s0_done got=%b%b%b want=100", done, busy, err); end
        total++; if (elem_count !== 12'd20 || beat_count !== 12'd3) begin bad++; $display("FAIL s0_counts got=%0d/%0d want=20/3", elem_count, beat_count); end
        tick();
        total++; if (done !== 1'b0 || elem_count !== 12'd20) begin bad++; $display("FAIL s0_pulse got=%b/%0d want=0/20", done, elem_count); end
    endtask

    task automatic test_wide_sew();
        do_start(2'd2, 12'd3);
        beat(8'hFF);
        beat(8'h0F);
        total++; if (done !== 1'b1 || elem_count !== 12'd3 || beat_count !== 12'd2) begin bad++; $display("FAIL s2_done got=%b/%0d/%0d want=1/3/2", done, elem_count, beat_count); end
        tick();
        do_start(2'd3, 12'd2);
        beat(8'hFF);
        total++; if (done !== 1'b0 || elem_count !== 12'd1) begin bad++; $display("FAIL s3_mid got=%b/%0d want=0/1", done, elem_count); end
        beat(8'hFF);
        total++; if (done !== 1'b1 || beat_count !== 12'd2 || elem_count !== 12'd2) begin bad++; $display("FAIL s3_done got=%b/%0d/%0d want=1/2/2", done, beat_count, elem_count); end
        tick();
    endtask

    task automatic test_mismatch();
        do_start(2'd1, 12'd5);
        beat(8'hFF);
        beat(8'h07);
        total++; if (err !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mm_flags got=err%b done%b rdy%b busy%b want=1000", err, done, in_ready, busy); end
        total++; if (err_beat !== 12'd1 || err_be !== 8'h07 || elem_count !== 12'd4) begin bad++; $display("FAIL mm_info got=%0d/%02h/%0d want=1/07/4", err_beat, err_be, elem_count); end
        tick(); tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL mm_sticky got=%b want=1", err); end
        do_start(2'd1, 12'd4);
        total++; if (err !== 1'b0 || busy !== 1'b1 || err_beat !== '0 || err_be !== '0) begin bad++; $display("FAIL mm_clear got=%b%b/%0d/%02h want=01/0/00", err, busy, err_beat, err_be); end
        beat(8'hFF);
        total++; if (done !== 1'b1 || err !== 1'b0 || elem_count !== 12'd4) begin bad++; $display("FAIL mm_recover got=%b%b/%0d want=10/4", done, err, elem_count); end
        tick();
        do_start(2'd0, 12'd8);
        beat(8'h00);
        total++; if (err !== 1'b1 || err_beat !== 12'd0 || err_be !== 8'h00 || beat_count !== 12'd0) begin bad++; $display("FAIL mm_zero got=%b/%0d/%02h/%0d want=1/0/00/0", err, err_beat, err_be, beat_count); end
        do_start(2'd0, 12'd8);
        beat(8'hFF);
        tick();
    endtask

    task automatic test_avl_zero();
        do_start(2'd0, 12'd0);
        total++; if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || beat_count !== '0) begin bad++; $display("FAIL z_done got=%b%b%b/%0d want=100/0", done, in_ready, busy, beat_count); end
        in_valid = 1'b1; in_be = 8'hFF;
        tick();
        in_valid = 1'b0;
        total++; if (done !== 1'b0 || in_ready !== 1'b0 || beat_count !== '0) begin bad++; $display("FAIL z_after got=%b%b/%0d want=00/0", done, in_ready, beat_count); end
    endtask

    task automatic test_illegal_sew();
        start0 = 1'b1; start_sew = 2'd3; start_avl = 12'd4;
        tick();
        start0 = 1'b0;
        $display("start0 sew=3 avl=4 err0=%b", err0);
        total++; if (err0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || err_beat0 !== '0 || err_be0 !== '0) begin bad++; $display("FAIL ill_sew got=%b%b%b/%0d/%02h want=100/0/00", err0, busy0, done0, err_beat0, err_be0); end
        total++; if (in_ready0 !== 1'b0 || elem_count0 !== '0 || beat_count0 !== '0) begin bad++; $display("FAIL ill_sew_rdy got=%b/%0d/%0d want=0/0/0", in_ready0, elem_count0, beat_count0); end
    endtask

    task automatic test_start_ignored();
        do_start(2'd0, 12'd16);
        beat(8'hFF);
        do_start(2'd2, 12'd5);
        total++; if (busy !== 1'b1 || elem_count !== 12'd8 || beat_count !== 12'd1) begin bad++; $display("FAIL ign_hold got=%b/%0d/%0d want=1/8/1", busy, elem_count, beat_count); end
        beat(8'hFF);
        total++; if (done !== 1'b1 || elem_count !== 12'd16 || beat_count !== 12'd2) begin bad++; $display("FAIL ign_done got=%b/%0d/%0d want=1/16/2", done, elem_count, beat_count); end
        tick();
    endtask

    task automatic test_async_reset();
        logic saw_done;
        do_start(2'd0, 12'd24);
        beat(8'hFF);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset asserted");
        total++; if (busy !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0 || elem_count !== '0 || beat_count !== '0) begin bad++; $display("FAIL ar_now got=%b%b%b/%0d/%0d want=000/0/0", busy, in_ready, err, elem_count, beat_count); end
        saw_done = 1'b0;
        in_valid = 1'b1; in_be = 8'hFF;
        repeat (2) begin tick(); if (done) saw_done = 1'b1; end
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        if (done) saw_done = 1'b1;
        total++; if (saw_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ar_nodone got=%b/%b want=0/0", saw_done, busy); end
        do_start(2'd0, 12'd24);
        beat(8'hFF);
        beat(8'hFF);
        beat(8'hFF);
        total++; if (done !== 1'b1 || elem_count !== 12'd24 || beat_count !== 12'd3 || err !== 1'b0) begin bad++; $display("FAIL ar_fresh got=%b/%0d/%0d/%b want=1/24/3/0", done, elem_count, beat_count, err); end
        tick();
    endtask

    initial begin
        start = 1'b0; start0 = 1'b0; start_sew = '0; start_avl = '0;
        in_valid = 1'b0; in_be = '0; rst_n = 1'b0;
        test_reset();
        test_sew0_gaps();
        test_wide_sew();
        test_mismatch();
        test_avl_zero();
        test_illegal_sew();
        test_start_ignored();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_be_checker.md
Name: vec_be_checker

Overview:
- Receiving-end decoder for per-beat byte enables on the vector data path.
- Accepts one vector transfer of `avl` elements at element width `sew` as a stream of DATA_WIDTH beats with byte enables.
- Checks each beat's byte enable against the mask implied by `sew`, `avl` and the beat index; counts accepted elements; signals done or a sticky error.
- Sits at the VRF write port and the store-data sink, ahead of the register/memory write.

Parameters:
- VLEN, 16384, vector register length in bits.
- AVL_WIDTH, $clog2(VLEN/8)+1, width of avl and of the element/beat counters.
- DATA_WIDTH, 64, beat width in bits.
- DW_B, DATA_WIDTH/8, byte enables per beat.
- SEW_WIDTH, 2, sew encoding width; element bytes W_B = 1<<sew.
- ENABLE_64_BIT, 1, when 0, sew=3 is illegal.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a transfer; sampled only in IDLE.
- start_sew  in  SEW_WIDTH  element width for the transfer.
- start_avl  in  AVL_WIDTH  element count for the transfer.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- in_be  in  DW_B  byte enable of the beat.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse: all avl elements received legally.
- err  out  1  sticky: illegal sew or byte-enable mismatch.
- err_beat  out  AVL_WIDTH  beat index of the first mismatch.
- err_be  out  DW_B  offending in_be value.
- elem_count  out  AVL_WIDTH  elements accepted so far.
- beat_count  out  AVL_WIDTH  beats accepted so far; this is the current dw offset.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; latched sew/avl cleared. Reset mid-transfer aborts it with no done or err.
- States:
  - IDLE: in_ready=0.
  - ACTIVE: in_ready=1, busy=1.
  - ERR: in_ready=0, err=1.
- IDLE transitions on start:
  - Latch start_sew and start_avl; clear elem_count, beat_count, err, err_beat, err_be.
  - If sew=3 && !ENABLE_64_BIT: go to ERR next cycle, err_beat=0, err_be=0.
  - Else if start_avl==0: done pulses the next cycle; stay IDLE. No beat is ever accepted.
  - Else: go to ACTIVE.
- start is ignored in ACTIVE. In ERR, start clears the error and is handled as from IDLE.
- Expected mask per beat, from latched values:
  - EPB = DW_B/W_B; rem = avl - elem_count; n = min(rem, EPB).
  - exp_be = low n*W_B bits set, rest 0.
  - This equals the mask produced for avl_dw_offset = beat_count.
- On handshake in ACTIVE with in_be == exp_be:
  - elem_count += n; beat_count += 1, both registered the next cycle.
  - If elem_count+n == avl: done pulses for exactly one cycle next cycle, busy drops the same cycle, state returns to IDLE. The counters hold their final values until the next start.
- On handshake with in_be != exp_be (partial element, gap, extra or missing bytes, or all-zero):
  - Next cycle: state ERR, err=1, err_beat=beat_count, err_be=in_be.
  - Counters do not advance. The beat counts as consumed.
- in_valid low in ACTIVE: no state change; any number of idle cycles is legal.
- Maximum: avl = VLEN/8 at sew=0 gives VLEN/DATA_WIDTH beats. Counters never wrap because AVL_WIDTH holds VLEN/8.
- done and err are never asserted together.
- Latency: one cycle from the final handshake to done, and one cycle from the bad handshake to err.

Test Plan:
- sew=0, avl=20, beats 0xFF, 0xFF, 0x0F with in_valid gaps between them -> done one cycle after the 3rd handshake; elem_count=20, beat_count=3, err=0.
- sew=2, avl=3, beats 0xFF then 0x0F -> done after the 2nd beat, elem_count=3. Variant sew=3, avl=2, beats 0xFF, 0xFF with ENABLE_64_BIT=1 -> done, beat_count=2.
- sew=1, avl=5, beats 0xFF then 0x07 (split element) -> err=1 the next cycle, err_beat=1, err_be=0x07, elem_count=4, in_ready=0. Then start with avl=4, beat 0xFF -> done, err cleared.
- start with avl=0 -> done pulses the cycle after start; in_ready stays 0; beat_count=0.
- ENABLE_64_BIT=0, start with sew=3 -> err=1 the next cycle, err_beat=0, busy=0. A start pulsed while ACTIVE (sew=0, avl=16, after 1 beat) is ignored and the transfer completes with elem_count=16.
- rst_n driven low asynchronously between beat 1 and beat 2 of a 3-beat transfer -> busy, in_ready, counters and err read 0 immediately; no done pulse. A fresh transfer after reset completes normally.
